buffered_ring_node: RTL and testbench

Parametrised, buffered successor to the one-dimensional interconnect node. Each of the three ingress channels (left neighbour, right neighbour, local core) has its own FIFO. A round-robin arbiter forwards one packet per cycle to the left, right or local egress. The route is chosen by comparing the packet's destination field with the node's own ID. Nodes chain into a 1-D array; downstream backpressure and ingress-full flags replace the fire-and-forget strobes of the previous node.

---
 rtl/buffered_ring_pkg.sv | 18 +
 rtl/ring_fifo.sv | 63 ++++++
 rtl/buffered_ring_node.sv | 163 ++++++++++++++++
 tb/tb_buffered_ring_node.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffered_ring_pkg.sv
// Shared port encoding for the buffered ring node and its arbiter.
package buffered_ring_pkg;

  typedef logic [1:0] port_t;

  localparam port_t PORT_LEFT  = 2'd0;
  localparam port_t PORT_RIGHT = 2'd1;
  localparam port_t PORT_SELF  = 2'd2;
  localparam port_t PORT_NONE  = 2'd3;

  localparam int NUM_PORTS = 3;

  // Round-robin successor over left -> right -> self.
  function automatic port_t next_port(input port_t p);
    return (p == PORT_SELF) ? PORT_LEFT : port_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/ring_fifo.sv
// Ingress FIFO: push/pop same edge, head visible combinationally, full/empty registered.
// Pushes into a full FIFO are discarded and flagged on overflow_o, even if it pops that cycle.
module ring_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_dat_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  assign do_push    = push_i && !full_q;
  assign do_pop     = pop_i && !empty_q;
  assign overflow_o = push_i && full_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (PTR_W+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/buffered_ring_node.sv
// 1-D ring node: three buffered ingresses, round-robin one grant per cycle, 2-edge min latency.
// A head waits while its target egress Rdy is low; strobes into a full ingress are dropped and counted.
module buffered_ring_node
  import buffered_ring_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NODE_ID = 0,
  parameter int DEPTH   = 4,
  parameter int DROP_W  = 8
) (
  input  logic              shiftInCLK,
  input  logic              shiftInRSTn,
  input  logic [DATA_W-1:0] shiftInLeftData,
  input  logic [DATA_W-1:0] shiftInRightData,
  input  logic [DATA_W-1:0] shiftInData,
  input  logic              shiftInLeftCS,
  input  logic              shiftInRightCS,
  input  logic              shiftInCS,
  output logic              shiftInLeftFull,
  output logic              shiftInRightFull,
  output logic              shiftInFull,
  output logic [DATA_W-1:0] shiftOutLeftData,
  output logic [DATA_W-1:0] shiftOutRightData,
  output logic [DATA_W-1:0] shiftOutData,
  output logic              shiftOutLeftCS,
  output logic              shiftOutRightCS,
  output logic              shiftOutCS,
  input  logic              shiftOutLeftRdy,
  input  logic              shiftOutRightRdy,
  input  logic              shiftOutRdy,
  output logic [1:0]        dataSource,
  output logic [1:0]        outputSelect,
  output logic [DROP_W-1:0] dropCount
);

  logic [DATA_W-1:0]    in_dat   [NUM_PORTS];
  logic [DATA_W-1:0]    head_dat [NUM_PORTS];
  logic [ADDR_W-1:0]    dest     [NUM_PORTS];
  port_t                tgt      [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_cs, egr_rdy, fifo_full, fifo_empty, fifo_ovf, pop, eligible;

  logic                 gnt_vld;
  port_t                gnt_src, gnt_tgt, cand;
  logic [DATA_W-1:0]    gnt_dat;

  logic [NUM_PORTS-1:0] out_cs_q, out_cs_d;
  logic [DATA_W-1:0]    out_dat_q [NUM_PORTS];
  logic [DATA_W-1:0]    out_dat_d [NUM_PORTS];
  port_t                src_q, src_d, sel_q, sel_d, rr_ptr_q, rr_ptr_d;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic [1:0]           drop_inc;
  logic [DROP_W:0]      drop_sum;

  assign in_dat[0] = shiftInLeftData;
  assign in_dat[1] = shiftInRightData;
  assign in_dat[2] = shiftInData;
  assign in_cs     = {shiftInCS, shiftInRightCS, shiftInLeftCS};
  assign egr_rdy   = {shiftOutRdy, shiftOutRightRdy, shiftOutLeftRdy};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ingress
    ring_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i     (shiftInCLK),
      .rst_ni    (shiftInRSTn),
      .push_i    (in_cs[g]),
      .push_dat_i(in_dat[g]),
      .pop_i     (pop[g]),
      .head_dat_o(head_dat[g]),
      .full_o    (fifo_full[g]),
      .empty_o   (fifo_empty[g]),
      .overflow_o(fifo_ovf[g])
    );
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dest[i] = head_dat[i][DATA_W-1 -: ADDR_W];
      if (int'(dest[i]) < NODE_ID) begin
        tgt[i] = PORT_LEFT;
      end else if (int'(dest[i]) > NODE_ID) begin
        tgt[i] = PORT_RIGHT;
      end else begin
        tgt[i] = PORT_SELF;
      end
      eligible[i] = !fifo_empty[i] && egr_rdy[tgt[i]];
    end
  end

  // First eligible head starting at the pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = PORT_NONE;
    gnt_tgt = PORT_NONE;
    gnt_dat = '0;
    cand    = rr_ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_vld && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_src = cand;
        gnt_tgt = tgt[cand];
        gnt_dat = head_dat[cand];
      end
      cand = next_port(cand);
    end
  end

  assign pop = gnt_vld ? (NUM_PORTS'(1) << gnt_src) : '0;

  always_comb begin
    out_cs_d  = '0;
    out_dat_d = out_dat_q;
    src_d     = PORT_NONE;
    sel_d     = PORT_NONE;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_vld) begin
      out_cs_d[gnt_tgt]  = 1'b1;
      out_dat_d[gnt_tgt] = gnt_dat;
      src_d              = gnt_src;
      sel_d              = gnt_tgt;
      rr_ptr_d           = next_port(gnt_src);
    end
  end

  assign drop_inc = 2'(fifo_ovf[0]) + 2'(fifo_ovf[1]) + 2'(fifo_ovf[2]);
  assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drop_inc);
  assign drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

  always_ff @(posedge shiftInCLK or negedge shiftInRSTn) begin
    if (!shiftInRSTn) begin
      out_cs_q  <= '0;
      out_dat_q <= '{default: '0};
      src_q     <= PORT_NONE;
      sel_q     <= PORT_NONE;
      rr_ptr_q  <= PORT_LEFT;
      drop_q    <= '0;
    end else begin
      out_cs_q  <= out_cs_d;
      out_dat_q <= out_dat_d;
      src_q     <= src_d;
      sel_q     <= sel_d;
      rr_ptr_q  <= rr_ptr_d;
      drop_q    <= drop_d;
    end
  end

  assign shiftInLeftFull   = fifo_full[0];
  assign shiftInRightFull  = fifo_full[1];
  assign shiftInFull       = fifo_full[2];
  assign shiftOutLeftCS    = out_cs_q[0];
  assign shiftOutRightCS   = out_cs_q[1];
  assign shiftOutCS        = out_cs_q[2];
  assign shiftOutLeftData  = out_dat_q[0];
  assign shiftOutRightData = out_dat_q[1];
  assign shiftOutData      = out_dat_q[2];
  assign dataSource        = src_q;
  assign outputSelect      = sel_q;
  assign dropCount         = drop_q;

endmodule

// File: tb/tb_buffered_ring_node.sv
// Bench for buffered_ring_node: directed scenarios plus random traffic against a queue-based model.
module tb_buffered_ring_node;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int NID = 5;
  localparam int DEP = 4;
  localparam int DRW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] in_dat [3];
  logic [2:0]    in_cs;
  logic [2:0]    rdy;
  logic [2:0]    o_full;
  logic [2:0]    o_cs;
  logic [DW-1:0] o_dat [3];
  logic [1:0]    o_src, o_sel;
  logic [DRW-1:0] o_drop;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue per ingress plus expected registered outputs.
  logic [DW-1:0] mq [3][$];
  int            m_ptr;
  logic [2:0]    e_cs;
  logic [DW-1:0] e_dat [3];
  logic [1:0]    e_src, e_sel;
  int            e_drop;

  always #5 clk = ~clk;

  buffered_ring_node #(
    .DATA_W(DW), .ADDR_W(AW), .NODE_ID(NID), .DEPTH(DEP), .DROP_W(DRW)
  ) dut (
    .shiftInCLK       (clk),
    .shiftInRSTn      (rst_n),
    .shiftInLeftData  (in_dat[0]),
    .shiftInRightData (in_dat[1]),
    .shiftInData      (in_dat[2]),
    .shiftInLeftCS    (in_cs[0]),
    .shiftInRightCS   (in_cs[1]),
    .shiftInCS        (in_cs[2]),
    .shiftInLeftFull  (o_full[0]),
    .shiftInRightFull (o_full[1]),
    .shiftInFull      (o_full[2]),
    .shiftOutLeftData (o_dat[0]),
    .shiftOutRightData(o_dat[1]),
    .shiftOutData     (o_dat[2]),
    .shiftOutLeftCS   (o_cs[0]),
    .shiftOutRightCS  (o_cs[1]),
    .shiftOutCS       (o_cs[2]),
    .shiftOutLeftRdy  (rdy[0]),
    .shiftOutRightRdy (rdy[1]),
    .shiftOutRdy      (rdy[2]),
    .dataSource       (o_src),
    .outputSelect     (o_sel),
    .dropCount        (o_drop)
  );

  function automatic int route(input logic [DW-1:0] p);
    int d;
    d = int'(p[DW-1:DW-AW]);
    if (d < NID) return 0;
    if (d > NID) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      mq[c].delete();
      e_dat[c] = '0;
    end
    m_ptr  = 0;
    e_cs   = '0;
    e_src  = 2'b11;
    e_sel  = 2'b11;
    e_drop = 0;
  endtask

  task automatic model_edge();
    int g;
    int t;
    int pre [3];
    g = -1;
    for (int c = 0; c < 3; c++) pre[c] = mq[c].size();
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (m_ptr + k) % 3;
      if (g < 0 && mq[c].size() > 0 && rdy[route(mq[c][0])]) g = c;
    end
    e_cs  = '0;
    e_src = 2'b11;
    e_sel = 2'b11;
    if (g >= 0) begin
      t        = route(mq[g][0]);
      e_cs[t]  = 1'b1;
      e_dat[t] = mq[g].pop_front();
      e_src    = 2'(g);
      e_sel    = 2'(t);
      m_ptr    = (g + 1) % 3;
    end
    for (int c = 0; c < 3; c++) begin
      if (in_cs[c]) begin
        if (pre[c] == DEP) begin
          if (e_drop < 255) e_drop++;
        end else begin
          mq[c].push_back(in_dat[c]);
        end
      end
    end
  endtask

  // One clock edge: model follows the DUT, then strobes are withdrawn.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    in_cs = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_cs = '0;
    rdy   = 3'b111;
    for (int c = 0; c < 3; c++) in_dat[c] = '0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_cs = '0;
    rdy   = 3'b111;
    for (int c = 0; c < 3; c++) in_dat[c] = '0;
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if (o_cs !== 3'b000) begin n_err++; $display("FAIL reset_cs: got %b want 000", o_cs); end
    n_vec++; if (o_full !== 3'b000) begin n_err++; $display("FAIL reset_full: got %b want 000", o_full); end
    n_vec++; if ({o_src, o_sel} !== 4'b1111) begin n_err++; $display("FAIL reset_src_sel: got %b want 1111", {o_src, o_sel}); end
    n_vec++; if (o_drop !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", o_drop); end
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (o_dat[c] !== 32'd0) begin n_err++; $display("FAIL reset_data%0d: got %h want 0", c, o_dat[c]); end
    end
  endtask

  task automatic test_basic_route();
    do_reset();
    in_dat[1] = 32'h3000_002A; in_cs[1] = 1'b1;
    tick();
    n_vec++; if (o_cs !== 3'b000) begin n_err++; $display("FAIL basic_early: cs %b want 000", o_cs); end
    tick();
    n_vec++; if (o_cs !== 3'b001) begin n_err++; $display("FAIL basic_cs: cs %b want 001", o_cs); end
    n_vec++; if (o_dat[0] !== 32'h3000_002A) begin n_err++; $display("FAIL basic_data: got %h want 3000002a", o_dat[0]); end
    n_vec++; if ({o_src, o_sel} !== 4'b0100) begin n_err++; $display("FAIL basic_src_sel: got %b want 0100", {o_src, o_sel}); end
    tick();
    n_vec++; if ({o_cs, o_src, o_sel} !== 7'b000_1111) begin n_err++; $display("FAIL basic_idle: got %b want 0001111", {o_cs, o_src, o_sel}); end
    n_vec++; if (o_dat[0] !== 32'h3000_002A) begin n_err++; $display("FAIL basic_hold: got %h want 3000002a", o_dat[0]); end
  endtask

  task automatic test_simultaneous();
    logic [2:0]    xcs [3];
    logic [DW-1:0] xd  [3];
    int            xe  [3];
    xcs = '{3'b100, 3'b010, 3'b001};
    xd  = '{32'h5000_0049, 32'h7000_0001, 32'h2000_0059};
    xe  = '{2, 1, 0};
    do_reset();
    in_dat[0] = 32'h5000_0049; in_dat[1] = 32'h7000_0001; in_dat[2] = 32'h2000_0059;
    in_cs = 3'b111;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (o_cs !== xcs[i]) begin n_err++; $display("FAIL simul_cs%0d: got %b want %b", i, o_cs, xcs[i]); end
      n_vec++; if (o_dat[xe[i]] !== xd[i]) begin n_err++; $display("FAIL simul_data%0d: got %h want %h", i, o_dat[xe[i]], xd[i]); end
      n_vec++; if ({o_src, o_sel} !== {2'(i), 2'(xe[i])}) begin n_err++; $display("FAIL simul_src_sel%0d: got %b want %b", i, {o_src, o_sel}, {2'(i), 2'(xe[i])}); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    rdy = 3'b101;
    for (int i = 0; i < 5; i++) begin
      in_dat[0] = 32'h9000_0000 + 32'(i); in_cs[0] = 1'b1;
      tick();
      if (i == 2) begin
        n_vec++; if (o_full[0] !== 1'b0) begin n_err++; $display("FAIL ovf_full_early: got %b want 0", o_full[0]); end
      end
      if (i == 3) begin
        n_vec++; if (o_full[0] !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", o_full[0]); end
      end
    end
    n_vec++; if (o_drop !== 8'd1) begin n_err++; $display("FAIL ovf_drop: got %0d want 1", o_drop); end
    rdy = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if ({o_cs, o_src} !== 5'b010_00) begin n_err++; $display("FAIL ovf_drain_cs%0d: got %b want 01000", i, {o_cs, o_src}); end
      n_vec++; if (o_dat[1] !== 32'h9000_0000 + 32'(i)) begin n_err++; $display("FAIL ovf_drain_data%0d: got %h want %h", i, o_dat[1], 32'h9000_0000 + 32'(i)); end
      if (i == 0) begin
        n_vec++; if (o_full[0] !== 1'b0) begin n_err++; $display("FAIL ovf_full_fall: got %b want 0", o_full[0]); end
      end
    end
    tick();
    n_vec++; if (o_cs !== 3'b000) begin n_err++; $display("FAIL ovf_tail: cs %b want 000", o_cs); end
  endtask

  task automatic test_fairness();
    logic [DW-1:0] xd;
    do_reset();
    rdy = 3'b110;
    for (int i = 0; i < 4; i++) begin
      in_dat[0] = 32'h0A00_0000 + 32'(i);
      in_dat[2] = 32'h0B00_0000 + 32'(i);
      in_cs = 3'b101;
      tick();
    end
    rdy = 3'b001;
    for (int i = 0; i < 8; i++) begin
      tick();
      xd = ((i % 2) == 0 ? 32'h0A00_0000 : 32'h0B00_0000) + 32'(i / 2);
      n_vec++; if ({o_cs, o_src} !== {3'b001, ((i % 2) == 0 ? 2'b00 : 2'b10)}) begin n_err++; $display("FAIL fair_grant%0d: got %b", i, {o_cs, o_src}); end
      n_vec++; if (o_dat[0] !== xd) begin n_err++; $display("FAIL fair_data%0d: got %h want %h", i, o_dat[0], xd); end
    end
    tick();
    n_vec++; if (o_cs !== 3'b000) begin n_err++; $display("FAIL fair_tail: cs %b want 000", o_cs); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 3'b011;
    in_dat[0] = 32'h5000_00AA; in_dat[1] = 32'h9000_00BB; in_cs = 3'b011;
    tick();
    tick();
    n_vec++; if ({o_cs, o_src} !== 5'b010_01) begin n_err++; $display("FAIL bp_right: got %b want 01001", {o_cs, o_src}); end
    n_vec++; if (o_dat[1] !== 32'h9000_00BB) begin n_err++; $display("FAIL bp_right_data: got %h want 900000bb", o_dat[1]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (o_cs !== 3'b000) begin n_err++; $display("FAIL bp_wait%0d: cs %b want 000", i, o_cs); end
    end
    n_vec++; if ({o_drop, o_full} !== 11'd0) begin n_err++; $display("FAIL bp_nodrop: drop %0d full %b want 0", o_drop, o_full); end
    rdy = 3'b111;
    tick();
    n_vec++; if ({o_cs, o_src} !== 5'b100_00) begin n_err++; $display("FAIL bp_local: got %b want 10000", {o_cs, o_src}); end
    n_vec++; if (o_dat[2] !== 32'h5000_00AA) begin n_err++; $display("FAIL bp_local_data: got %h want 500000aa", o_dat[2]); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    in_dat[2] = 32'h0000_0077; in_cs[2] = 1'b1;
    tick();
    in_dat[0] = 32'h1000_0001; in_dat[1] = 32'h2000_0002; in_dat[2] = 32'h3000_0003;
    in_cs = 3'b111;
    tick();
    rdy = 3'b000;
    n_vec++; if (o_cs !== 3'b001 || o_dat[0] !== 32'h77) begin n_err++; $display("FAIL mid_pre: cs %b data %h want 001/77", o_cs, o_dat[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({o_cs, o_full, o_src, o_sel, o_drop} !== {6'b0, 4'b1111, 8'd0}) begin n_err++; $display("FAIL mid_rst_ctl: got %b", {o_cs, o_full, o_src, o_sel, o_drop}); end
    n_vec++; if (o_dat[0] !== 32'd0) begin n_err++; $display("FAIL mid_rst_data: got %h want 0", o_dat[0]); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++; if ({o_cs, o_src} !== 5'b000_11) begin n_err++; $display("FAIL mid_quiet%0d: got %b want 00011", i, {o_cs, o_src}); end
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    rdy = 3'b000;
    for (int i = 0; i < 95; i++) begin
      for (int c = 0; c < 3; c++) in_dat[c] = $urandom;
      in_cs = 3'b111;
      tick();
      if (i == 4) begin
        n_vec++; if (o_drop !== 8'd3) begin n_err++; $display("FAIL sat_triple: got %0d want 3", o_drop); end
      end
    end
    n_vec++; if (o_drop !== 8'd255) begin n_err++; $display("FAIL sat_cap: got %0d want 255", o_drop); end
    n_vec++; if (o_full !== 3'b111) begin n_err++; $display("FAIL sat_full: got %b want 111", o_full); end
  endtask

  task automatic test_random();
    logic [2:0] xf;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < 3; c++) begin
        in_dat[c] = $urandom;
        in_cs[c]  = ($urandom_range(0, 2) != 0);
        rdy[c]    = (n < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      end
      tick();
      for (int c = 0; c < 3; c++) xf[c] = (mq[c].size() == DEP);
      n_vec++; if ({o_cs, o_src, o_sel} !== {e_cs, e_src, e_sel}) begin n_err++; $display("FAIL rnd_ctl@%0d: got %b want %b", n, {o_cs, o_src, o_sel}, {e_cs, e_src, e_sel}); end
      n_vec++; if (o_full !== xf) begin n_err++; $display("FAIL rnd_full@%0d: got %b want %b", n, o_full, xf); end
      n_vec++; if (int'(o_drop) != e_drop) begin n_err++; $display("FAIL rnd_drop@%0d: got %0d want %0d", n, o_drop, e_drop); end
      for (int c = 0; c < 3; c++) begin
        n_vec++; if (o_dat[c] !== e_dat[c]) begin n_err++; $display("FAIL rnd_data%0d@%0d: got %h want %h", c, n, o_dat[c], e_dat[c]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_simultaneous();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    test_drop_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
